mem_to_bmb: RTL



---
 rtl/bmb_pkg.sv | 19 +
 rtl/bmb_cmd_reg.sv | 49 ++++
 rtl/mem_to_bmb.sv | 155 +++++++++++++++
 3 files changed

// File: rtl/bmb_pkg.sv
// Shared types and helpers for the mem_to_bmb bridge.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package bmb_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_CMD  = 2'd1,
    ST_RSP  = 2'd2
  } mem_to_bmb_state_e;

  // BMB size field is log2 of the byte count of one beat.
  function automatic int bmb_size_for(input int data_size);
    return $clog2(data_size / 8);
  endfunction

  localparam logic BMB_UNCACHED_DEFAULT = 1'b1;

endpackage

// File: rtl/bmb_cmd_reg.sv
// One-entry holding register for a BMB command payload.
// Latency: 1 cycle from in_valid to out_valid.
// Backpressure: in_ready is low while the entry is full; the payload is held until out_ready.
// Ports: clk_i/rst_i (sync, active-high); in_* load side; out_* drain side.
module bmb_cmd_reg #(
  parameter int AddrSize = 32,
  parameter int DataSize = 64
) (
  input  logic                    clk_i,
  input  logic                    rst_i,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [AddrSize-1:0]     in_addr,
  input  logic [DataSize-1:0]     in_data,
  input  logic [DataSize/8-1:0]   in_mask,
  input  logic                    in_wr,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [AddrSize-1:0]     out_addr,
  output logic [DataSize-1:0]     out_data,
  output logic [DataSize/8-1:0]   out_mask,
  output logic                    out_wr
);

  logic full_q;

  assign in_ready  = !full_q;
  assign out_valid = full_q;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      full_q   <= 1'b0;
      out_addr <= '0;
      out_data <= '0;
      out_mask <= '0;
      out_wr   <= 1'b0;
    end else if (in_valid && in_ready) begin
      full_q   <= 1'b1;
      out_addr <= in_addr;
      out_data <= in_data;
      out_mask <= in_mask;
      out_wr   <= in_wr;
    end else if (out_valid && out_ready) begin
      // Payload is left in place; only the valid flag drops.
      full_q <= 1'b0;
    end
  end

endmodule

// File: rtl/mem_to_bmb.sv
// Bridges a req/gnt memory initiator onto a BMB initiator, one transaction in flight.
// Latency: read gnt->rvalid 3 cycles, write 2 cycles (ready=1, 1-cycle responder).
// Backpressure: mem_gnt only in IDLE; command held stable until bmb_cmd_ready; rsp has none.
// Ports: mem_* requester side, bmb_cmd_* / bmb_rsp_* BMB side, spurious_rsp_o sticky error.
// Optional: define MEM_TO_BMB_TIMEOUT_EN to abandon reads after TimeoutCycles RSP cycles.
module mem_to_bmb
  import bmb_pkg::*;
#(
  parameter int AddrSize      = 32,
  parameter int DataSize      = 64,
  parameter int PayloadBits   = 2,
  parameter int TimeoutCycles = 256
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  input  logic                   mem_req,
  output logic                   mem_gnt,
  input  logic [AddrSize-1:0]    mem_addr,
  input  logic [DataSize-1:0]    mem_wdata,
  input  logic [DataSize/8-1:0]  mem_strb,
  input  logic                   mem_we,
  output logic                   mem_rvalid,
  output logic [DataSize-1:0]    mem_rdata,
  output logic                   mem_err,
  output logic                   bmb_cmd_valid,
  input  logic                   bmb_cmd_ready,
  output logic [AddrSize-1:0]    bmb_cmd_payload_address,
  output logic [PayloadBits-1:0] bmb_cmd_payload_size,
  output logic                   bmb_cmd_payload_wr,
  output logic                   bmb_cmd_payload_uncached,
  output logic [DataSize-1:0]    bmb_cmd_payload_data,
  output logic [DataSize/8-1:0]  bmb_cmd_payload_mask,
  output logic                   bmb_cmd_payload_last,
  input  logic                   bmb_rsp_valid,
  input  logic [DataSize-1:0]    bmb_rsp_payload_data,
  input  logic                   bmb_rsp_payload_last,
  input  logic                   bmb_rsp_payload_error,
  output logic                   spurious_rsp_o
);

  mem_to_bmb_state_e state_q, state_d;

  logic                  cmd_push;
  logic                  cmd_in_ready;
  logic                  cmd_fire;
  logic [DataSize/8-1:0] cmd_mask;
  logic                  timeout_hit;
  logic                  rvalid_q;
  logic [DataSize-1:0]   rdata_q;
  logic                  err_q;
  logic                  spurious_q;
  logic                  unused_sigs;

  assign bmb_cmd_payload_size     = PayloadBits'(bmb_size_for(DataSize));
  assign bmb_cmd_payload_uncached = BMB_UNCACHED_DEFAULT;
  assign bmb_cmd_payload_last     = 1'b1;

  assign mem_gnt  = (state_q == ST_IDLE);
  assign cmd_push = mem_gnt && mem_req;
  // Reads always fetch the full beat, so only writes carry the requester strobes.
  assign cmd_mask = mem_we ? mem_strb : '1;
  assign cmd_fire = bmb_cmd_valid && bmb_cmd_ready;

  // The entry is empty whenever the FSM is in IDLE, so in_ready adds nothing to the push.
  assign unused_sigs = ^{bmb_rsp_payload_last, cmd_in_ready};

  bmb_cmd_reg #(
    .AddrSize(AddrSize),
    .DataSize(DataSize)
  ) u_cmd_reg (
    .clk_i    (clk_i),
    .rst_i    (rst_i),
    .in_valid (cmd_push),
    .in_ready (cmd_in_ready),
    .in_addr  (mem_addr),
    .in_data  (mem_wdata),
    .in_mask  (cmd_mask),
    .in_wr    (mem_we),
    .out_valid(bmb_cmd_valid),
    .out_ready(bmb_cmd_ready),
    .out_addr (bmb_cmd_payload_address),
    .out_data (bmb_cmd_payload_data),
    .out_mask (bmb_cmd_payload_mask),
    .out_wr   (bmb_cmd_payload_wr)
  );

`ifdef MEM_TO_BMB_TIMEOUT_EN
  localparam int CntW = $clog2(TimeoutCycles + 1);
  logic [CntW-1:0] to_cnt_q;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      to_cnt_q <= '0;
    end else if (state_q == ST_CMD && cmd_fire) begin
      to_cnt_q <= '0;
    end else if (state_q == ST_RSP && !bmb_rsp_valid) begin
      to_cnt_q <= to_cnt_q + 1'b1;
    end
  end

  // Fires on the RSP cycle that brings the count to TimeoutCycles; a response
  // in the same cycle takes priority.
  assign timeout_hit = (state_q == ST_RSP) && !bmb_rsp_valid &&
                       (to_cnt_q == CntW'(TimeoutCycles - 1));
`else
  assign timeout_hit = 1'b0;
`endif

  always_ff @(posedge clk_i) begin
    if (rst_i) state_q <= ST_IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (mem_req) state_d = ST_CMD;
      ST_CMD:  if (cmd_fire) state_d = bmb_cmd_payload_wr ? ST_IDLE : ST_RSP;
      ST_RSP:  if (bmb_rsp_valid || timeout_hit) state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      rvalid_q   <= 1'b0;
      rdata_q    <= '0;
      err_q      <= 1'b0;
      spurious_q <= 1'b0;
    end else begin
      rvalid_q <= 1'b0;
      if (state_q == ST_CMD && cmd_fire && bmb_cmd_payload_wr) begin
        rvalid_q <= 1'b1;
        rdata_q  <= '0;
        err_q    <= 1'b0;
      end else if (state_q == ST_RSP && bmb_rsp_valid) begin
        rvalid_q <= 1'b1;
        rdata_q  <= bmb_rsp_payload_data;
        err_q    <= bmb_rsp_payload_error;
      end else if (timeout_hit) begin
        rvalid_q <= 1'b1;
        rdata_q  <= '0;
        err_q    <= 1'b1;
      end
      // Covers the read-handshake cycle too: a response cannot precede its command.
      if (bmb_rsp_valid && state_q != ST_RSP) spurious_q <= 1'b1;
    end
  end

  assign mem_rvalid     = rvalid_q;
  assign mem_rdata      = rdata_q;
  assign mem_err        = err_q;
  assign spurious_rsp_o = spurious_q;

endmodule
